// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - instruction fetch stage: PC-to-memory request, in-order response matching, decode buffer
module instr_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          FetchReset,
    input  logic [AW-1:0] PCOut,
    input  logic          Redirect,
    output logic          MemReqValid,
    output logic [AW-1:0] MemReqAddr,
    input  logic          MemReqReady,
    input  logic          MemRespValid,
    input  logic [31:0]   MemRespData,
    output logic          InstrValid,
    output logic [31:0]   Instr,
    output logic [AW-1:0] InstrPC,
    input  logic          InstrReady,
    output logic          PCHold
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   L_DEPTH = DEPTH[CW:0];
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    // Entry storage; pc/data need no reset because filled/count gate their use.
    logic [AW-1:0]    r_pc   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;   // allocated entries
    logic [CW-1:0] r_pend;    // allocated entries still waiting for their response
    logic [CW-1:0] r_drop;    // in-flight responses belonging to flushed requests

    logic w_active;
    logic w_credit_ok;
    logic w_alloc;
    logic w_resp_drop;
    logic w_resp_fill;
    logic w_resp_any;
    logic w_deq;

    // Outstanding requests (live + flushed) never exceed DEPTH, so a response always has a home.
    assign w_active    = !FetchReset && !Redirect;
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_drop}) < L_DEPTH;
    assign MemReqValid = w_active && w_credit_ok;
    assign MemReqAddr  = PCOut;
    assign w_alloc     = MemReqValid && MemReqReady;
    assign PCHold      = w_active && !w_alloc;

    // Flushed responses are consumed first; a response with nothing to fill is ignored.
    assign w_resp_drop = MemRespValid && (r_drop != '0);
    assign w_resp_fill = MemRespValid && (r_drop == '0) && (r_pend != '0);
    assign w_resp_any  = w_resp_drop || w_resp_fill;

    assign InstrValid = w_active && (r_count != '0) && r_filled[r_head];
    assign Instr      = r_data[r_head];
    assign InstrPC    = r_pc[r_head];
    assign w_deq      = InstrValid && InstrReady;

    // Buffer bookkeeping: reset, flush, or concurrent allocate/fill/dequeue.
    always_ff @(posedge clk) begin
        if (FetchReset) begin
            r_head   <= '0;
            r_fill   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_pend   <= '0;
            r_drop   <= '0;
            r_filled <= '0;
        end else if (Redirect) begin
            // Unfilled entries become drops; this cycle's response is accounted before the flush.
            r_head   <= '0;
            r_fill   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_pend   <= '0;
            r_filled <= '0;
            r_drop   <= r_drop + r_pend - {{(CW-1){1'b0}}, w_resp_any};
        end else begin
            if (w_alloc) begin
                r_pc[r_tail]     <= PCOut;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PTR_ONE;
            end
            if (w_resp_fill) begin
                r_data[r_fill]   <= MemRespData;
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + PTR_ONE;
            end
            if (w_deq) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + PTR_ONE;
            end
            r_count <= r_count + {{(CW-1){1'b0}}, w_alloc} - {{(CW-1){1'b0}}, w_deq};
            r_pend  <= r_pend + {{(CW-1){1'b0}}, w_alloc} - {{(CW-1){1'b0}}, w_resp_fill};
            r_drop  <= r_drop - {{(CW-1){1'b0}}, w_resp_drop};
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - directed self-checking bench for instr_fetch_buffer
module tb_instr_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          FetchReset;
    logic [AW-1:0] PCOut;
    logic          Redirect;
    logic          MemReqValid;
    logic [AW-1:0] MemReqAddr;
    logic          MemReqReady;
    logic          MemRespValid;
    logic [31:0]   MemRespData;
    logic          InstrValid;
    logic [31:0]   Instr;
    logic [AW-1:0] InstrPC;
    logic          InstrReady;
    logic          PCHold;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int k     = 1;
    logic [31:0] pc;
    logic [31:0] rd_target;

    logic [31:0] q_due  [$];
    logic [31:0] q_addr [$];
    logic [31:0] log_pc   [$];
    logic [31:0] log_data [$];

    always #5 clk = ~clk;

    instr_fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .FetchReset   (FetchReset),
        .PCOut        (PCOut),
        .Redirect     (Redirect),
        .MemReqValid  (MemReqValid),
        .MemReqAddr   (MemReqAddr),
        .MemReqReady  (MemReqReady),
        .MemRespValid (MemRespValid),
        .MemRespData  (MemRespData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady),
        .PCHold       (PCHold)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: sample handshakes before the edge, then advance PC and memory model.
    task automatic step();
        logic acc, hold, rst, rd;
        logic [31:0] acc_addr;
        #1;
        acc      = MemReqValid && MemReqReady;
        acc_addr = MemReqAddr;
        hold     = PCHold;
        rst      = FetchReset;
        rd       = Redirect;
        if (InstrValid && InstrReady) begin
            log_pc.push_back(InstrPC);
            log_data.push_back(Instr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q_due.delete();
            q_addr.delete();
            pc = 0;
        end else begin
            if (acc) begin
                q_due.push_back(cyc - 1 + k);
                q_addr.push_back(acc_addr);
            end
            if (rd) pc = rd_target;
            else if (!hold) pc = pc + 1;
        end
        PCOut        = pc;
        MemRespValid = 1'b0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            MemRespValid = 1'b1;
            MemRespData  = mem_word(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        FetchReset  = 1'b1;
        Redirect    = 1'b0;
        MemReqReady = 1'b1;
        run(n);
        FetchReset = 1'b0;
        cyc = 0;
        log_pc.delete();
        log_data.delete();
        settle();
    endtask

    initial begin
        int cnt;
        int bad_order;

        FetchReset   = 1'b1;
        Redirect     = 1'b0;
        MemReqReady  = 1'b1;
        MemRespValid = 1'b0;
        MemRespData  = '0;
        InstrReady   = 1'b1;
        pc           = 0;
        PCOut        = 0;
        rd_target    = 0;
        settle();
        chk("rst_reqvalid", MemReqValid, 0);
        chk("rst_instrvalid", InstrValid, 0);
        chk("rst_pchold", PCHold, 0);

        // Basic stream, k=1
        k = 1;
        do_reset(2);
        chk("rst_count", dut.r_count, 0);
        chk("rst_drop", dut.r_drop, 0);
        for (int c = 0; c < 12; c++) begin
            chk("bs_pchold", PCHold, 0);
            chk("bs_valid", InstrValid, (c >= 2));
            if (c >= 2) begin
                chk("bs_pc", InstrPC, c - 2);
                chk("bs_data", Instr, mem_word(c - 2));
            end
            step();
        end

        // Decode stall fills the buffer, then drains in order
        do_reset(1);
        InstrReady = 1'b0;
        settle();
        run(4);
        chk("st_reqvalid", MemReqValid, 0);
        chk("st_pchold", PCHold, 1);
        chk("st_pcout", PCOut, 4);
        chk("st_headpc", InstrPC, 0);
        chk("st_headvalid", InstrValid, 1);
        run(2);
        chk("st_reqvalid2", MemReqValid, 0);
        chk("st_pcout2", PCOut, 4);
        InstrReady = 1'b1;
        settle();
        step();
        chk("st_req4_valid", MemReqValid, 1);
        chk("st_req4_addr", MemReqAddr, 4);
        run(8);
        chk("st_len", (log_pc.size() >= 6), 1);
        for (int i = 0; i < 6; i++) chk("st_order", log_pc[i], i);
        chk("st_data3", log_data[3], mem_word(3));

        // Memory stall at PC 7
        do_reset(1);
        InstrReady = 1'b1;
        settle();
        run(7);
        chk("ms_pcout", PCOut, 7);
        MemReqReady = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("ms_pchold", PCHold, 1);
            chk("ms_addr", MemReqAddr, 7);
            step();
        end
        MemReqReady = 1'b1;
        settle();
        run(10);
        cnt = 0;
        bad_order = 0;
        for (int i = 0; i < log_pc.size(); i++) begin
            if (log_pc[i] == 7) cnt++;
            if (log_pc[i] != i) bad_order++;
        end
        chk("ms_len", (log_pc.size() >= 9), 1);
        chk("ms_one7", cnt, 1);
        chk("ms_order", bad_order, 0);

        // Flush with two responses in flight, k=3
        do_reset(1);
        k = 3;
        Redirect  = 1'b1;
        rd_target = 10;
        settle();
        chk("fl_noreq", MemReqValid, 0);
        step();
        Redirect = 1'b0;
        settle();
        chk("fl_addr10", MemReqAddr, 10);
        chk("fl_valid10", MemReqValid, 1);
        run(2);
        Redirect  = 1'b1;
        rd_target = 32'h40;
        settle();
        chk("fl_rd_noreq", MemReqValid, 0);
        chk("fl_rd_pchold", PCHold, 0);
        step();
        Redirect = 1'b0;
        settle();
        chk("fl_drop", dut.r_drop, 2);
        chk("fl_count", dut.r_count, 0);
        chk("fl_addr40", MemReqAddr, 32'h40);
        run(12);
        cnt = 0;
        for (int i = 0; i < log_pc.size(); i++)
            if (log_pc[i] == 10 || log_pc[i] == 11) cnt++;
        chk("fl_len", (log_pc.size() >= 1), 1);
        chk("fl_first", log_pc[0], 32'h40);
        chk("fl_firstdata", log_data[0], mem_word(32'h40));
        chk("fl_nowrong", cnt, 0);

        // Redirect, response and ready head all in the same cycle, k=2
        do_reset(1);
        k = 2;
        InstrReady = 1'b1;
        settle();
        run(3);
        chk("se_headvalid", InstrValid, 1);
        Redirect  = 1'b1;
        rd_target = 32'h80;
        settle();
        chk("se_nodeq", InstrValid, 0);
        step();
        Redirect = 1'b0;
        settle();
        chk("se_empty", InstrValid, 0);
        chk("se_count", dut.r_count, 0);
        chk("se_drop", dut.r_drop, 1);
        run(10);
        chk("se_len", (log_pc.size() >= 1), 1);
        chk("se_first", log_pc[0], 32'h80);

        // Reset mid-operation with 3 entries, 2 filled
        do_reset(1);
        k = 1;
        InstrReady = 1'b0;
        settle();
        run(3);
        chk("mr_count3", dut.r_count, 3);
        chk("mr_headvalid", InstrValid, 1);
        FetchReset = 1'b1;
        settle();
        chk("mr_rst_req", MemReqValid, 0);
        chk("mr_rst_valid", InstrValid, 0);
        chk("mr_rst_hold", PCHold, 0);
        step();
        FetchReset = 1'b0;
        cyc = 0;
        settle();
        chk("mr_valid", InstrValid, 0);
        chk("mr_count", dut.r_count, 0);
        chk("mr_drop", dut.r_drop, 0);
        chk("mr_addr", MemReqAddr, 0);
        chk("mr_reqvalid", MemReqValid, 1);
        InstrReady = 1'b1;
        log_pc.delete();
        log_data.delete();
        settle();
        run(8);
        chk("mr_len", (log_pc.size() >= 3), 1);
        for (int i = 0; i < 3; i++) chk("mr_order", log_pc[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
